// File: rtl/exmem_pipe_reg.sv
// ---------------------------------------------------------------------------
// exmem_pipe_reg
//
// EX->MEM pipeline register for the pipelined RISC-V core. It carries the ALU
// result, store data, destination register, PC+4 and the MEM/WB control bits
// through DEPTH register stages. It adds a per-stage valid bit, stall (hold),
// flush (bubble insertion) and a saturating count of bubbles seen at the
// output, so the hazard unit can drive it directly.
//
// Parameters
//   XLEN   width of the data and PC fields
//   RA_W   register-address width
//   DEPTH  number of register stages, 1..4 (values above 1 serve
//          multi-cycle memory paths)
//   CNT_W  bubble-counter width
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall_m, flush_m    hold all stages / clear all stages (flush wins)
//   valid_e             EX-stage instruction valid
//   *_e                 EX-stage payload and control inputs
//   valid_m             valid bit of the output stage
//   *_m                 output-stage payload; reg_write_m and mem_write_m
//                       are gated with valid_m
//   bubble_cnt          saturating count of bubbles presented at the output
// ---------------------------------------------------------------------------
module exmem_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_m,
    input  logic             flush_m,
    input  logic             valid_e,
    input  logic [XLEN-1:0]  alu_result_e,
    input  logic [XLEN-1:0]  write_data_e,
    input  logic [RA_W-1:0]  rd_e,
    input  logic [XLEN-1:0]  pc_plus4_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic [1:0]       result_src_e,
    output logic             valid_m,
    output logic [XLEN-1:0]  alu_result_m,
    output logic [XLEN-1:0]  write_data_m,
    output logic [RA_W-1:0]  rd_m,
    output logic [XLEN-1:0]  pc_plus4_m,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [1:0]       result_src_m,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Reject unsupported chain lengths at elaboration time.
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("exmem_pipe_reg: DEPTH must be in 1..4");
    end

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] pc_plus4;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_in;
    stage_t stage_out;

    // Incoming entry; a bubble (valid_e = 0) is still written so the data
    // path has no extra enable, and the gated enables keep it harmless.
    always_comb begin
        stage_in            = '0;
        stage_in.valid      = valid_e;
        stage_in.alu_result = alu_result_e;
        stage_in.write_data = write_data_e;
        stage_in.rd         = rd_e;
        stage_in.pc_plus4   = pc_plus4_e;
        stage_in.reg_write  = reg_write_e;
        stage_in.mem_write  = mem_write_e;
        stage_in.result_src = result_src_e;
    end

    // Priority per edge: flush > stall > advance.
    // NOTE: every stage register, payload included, is reset so the outputs
    // read a defined 0 during reset; this is a short register chain, not a
    // RAM, so resetting it costs nothing structurally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush_m) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall_m) begin
            // NOTE: non-blocking assignments make every stage sample the
            // pre-edge value of its predecessor, regardless of loop order.
            stage_q[0] <= stage_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign stage_out    = stage_q[DEPTH-1];
    assign valid_m      = stage_out.valid;
    assign alu_result_m = stage_out.alu_result;
    assign write_data_m = stage_out.write_data;
    assign rd_m         = stage_out.rd;
    assign pc_plus4_m   = stage_out.pc_plus4;
    assign result_src_m = stage_out.result_src;
    // Side-effecting enables are killed for bubbles; data fields pass ungated.
    assign reg_write_m  = stage_out.valid & stage_out.reg_write;
    assign mem_write_m  = stage_out.valid & stage_out.mem_write;

    // Counts edges at which an invalid entry sits at the output and the
    // pipe is not held. A flush edge still counts; flush never clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!stall_m && !valid_m && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_exmem_pipe_reg
//
// Directed bench for exmem_pipe_reg. Three instances share clock, reset and
// inputs: DEPTH=1/CNT_W=16, DEPTH=3/CNT_W=16 and DEPTH=1/CNT_W=4. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_exmem_pipe_reg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall_m;
    logic            flush_m;
    logic            valid_e;
    logic [XLEN-1:0] alu_result_e;
    logic [XLEN-1:0] write_data_e;
    logic [RA_W-1:0] rd_e;
    logic [XLEN-1:0] pc_plus4_e;
    logic            reg_write_e;
    logic            mem_write_e;
    logic [1:0]      result_src_e;

    // DEPTH = 1, CNT_W = 16
    logic            a_valid, a_rw, a_mw;
    logic [XLEN-1:0] a_alu, a_wd, a_pc;
    logic [RA_W-1:0] a_rd;
    logic [1:0]      a_rs;
    logic [15:0]     a_cnt;
    // DEPTH = 3, CNT_W = 16
    logic            b_valid, b_rw, b_mw;
    logic [XLEN-1:0] b_alu, b_wd, b_pc;
    logic [RA_W-1:0] b_rd;
    logic [1:0]      b_rs;
    logic [15:0]     b_cnt;
    // DEPTH = 1, CNT_W = 4
    logic            c_valid, c_rw, c_mw;
    logic [XLEN-1:0] c_alu, c_wd, c_pc;
    logic [RA_W-1:0] c_rd;
    logic [1:0]      c_rs;
    logic [3:0]      c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exmem_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
        .valid_e(valid_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .rd_e(rd_e), .pc_plus4_e(pc_plus4_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .valid_m(a_valid), .alu_result_m(a_alu), .write_data_m(a_wd), .rd_m(a_rd),
        .pc_plus4_m(a_pc), .reg_write_m(a_rw), .mem_write_m(a_mw),
        .result_src_m(a_rs), .bubble_cnt(a_cnt)
    );

    exmem_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
        .valid_e(valid_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .rd_e(rd_e), .pc_plus4_e(pc_plus4_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .valid_m(b_valid), .alu_result_m(b_alu), .write_data_m(b_wd), .rd_m(b_rd),
        .pc_plus4_m(b_pc), .reg_write_m(b_rw), .mem_write_m(b_mw),
        .result_src_m(b_rs), .bubble_cnt(b_cnt)
    );

    exmem_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m),
        .valid_e(valid_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
        .rd_e(rd_e), .pc_plus4_e(pc_plus4_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .valid_m(c_valid), .alu_result_m(c_alu), .write_data_m(c_wd), .rd_m(c_rd),
        .pc_plus4_m(c_pc), .reg_write_m(c_rw), .mem_write_m(c_mw),
        .result_src_m(c_rs), .bubble_cnt(c_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between edges; leaves time at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] alu, input logic [RA_W-1:0] rd,
                         input logic rw, input logic mw);
        valid_e      = v;
        alu_result_e = alu;
        write_data_e = alu ^ 32'hFFFF_0000;
        rd_e         = rd;
        pc_plus4_e   = alu + 32'd4;
        reg_write_e  = rw;
        mem_write_e  = mw;
        result_src_e = 2'b01;
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_m = 1'b0;
        flush_m = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        result_src_e = 2'b00;

        // ---- Reset then stream, DEPTH = 1 ----
        #3;
        check("rst_valid", a_valid, 0);
        check("rst_alu", a_alu, 0);
        check("rst_cnt", a_cnt, 0);
        drive(1'b1, 32'h0000_00A5, 5'd5, 1'b1, 1'b0);
        tick();  // edge during reset must not load anything
        check("rst_hold_alu", a_alu, 0);
        check("rst_hold_rw", a_rw, 0);
        check("rst_hold_d3_valid", b_valid, 0);
        rst_n = 1'b1;
        tick();
        check("stream_alu", a_alu, 32'hA5);
        check("stream_rd", a_rd, 5);
        check("stream_rw", a_rw, 1);
        check("stream_valid", a_valid, 1);
        check("stream_wd", a_wd, 32'hFFFF_00A5);
        check("stream_pc", a_pc, 32'hA9);

        // ---- Stall hold ----
        drive(1'b1, 32'h1234, 5'd7, 1'b1, 1'b1);
        tick();
        check("stall_load", a_alu, 32'h1234);
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5555 + 32'(i), 5'd9, 1'b1, 1'b1);
            tick();
            check("stall_hold_alu", a_alu, 32'h1234);
            check("stall_hold_rd", a_rd, 7);
        end
        stall_m = 1'b0;
        tick();
        check("stall_release_alu", a_alu, 32'h5557);
        check("stall_release_rd", a_rd, 9);

        // ---- Flush vs stall (valid entry with both enables at output) ----
        check("pre_flush_mw", a_mw, 1);
        flush_m = 1'b1;
        stall_m = 1'b1;
        tick();
        flush_m = 1'b0;
        stall_m = 1'b0;
        check("flush_valid", a_valid, 0);
        check("flush_rw", a_rw, 0);
        check("flush_mw", a_mw, 0);
        check("flush_alu", a_alu, 0);
        check("flush_wd", a_wd, 0);
        check("flush_rd", a_rd, 0);
        check("flush_pc", a_pc, 0);
        check("flush_rs", a_rs, 0);

        // ---- DEPTH = 3 latency and flush ----
        do_reset();
        drive(1'b1, 32'hA, 5'd1, 1'b1, 1'b0);
        tick();
        check("d3_e1_valid", b_valid, 0);
        drive(1'b1, 32'hB, 5'd2, 1'b1, 1'b0);
        tick();
        check("d3_e2_valid", b_valid, 0);
        drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
        tick();
        check("d3_A_valid", b_valid, 1);
        check("d3_A_alu", b_alu, 32'hA);
        drive(1'b1, 32'hD, 5'd4, 1'b1, 1'b0);
        tick();
        check("d3_B_alu", b_alu, 32'hB);
        check("d3_B_rd", b_rd, 2);
        drive(1'b1, 32'hE, 5'd5, 1'b1, 1'b0);
        tick();
        check("d3_C_alu", b_alu, 32'hC);
        check("d3_C_rw", b_rw, 1);
        flush_m = 1'b1;  // stages now hold E, D, C
        drive(1'b1, 32'hF, 5'd6, 1'b1, 1'b0);
        tick();
        flush_m = 1'b0;
        check("d3_flush_valid", b_valid, 0);
        check("d3_flush_alu", b_alu, 0);
        drive(1'b1, 32'h6, 5'd7, 1'b1, 1'b0);
        tick();
        check("d3_refill1_valid", b_valid, 0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        check("d3_refill2_valid", b_valid, 0);
        tick();
        check("d3_G_valid", b_valid, 1);
        check("d3_G_alu", b_alu, 32'h6);

        // ---- Bubble gating and count, DEPTH = 1 ----
        do_reset();
        drive(1'b0, 32'h77, 5'd8, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("bub_rw", a_rw, 0);
        check("bub_mw", a_mw, 0);
        check("bub_cnt4", a_cnt, 4);
        check("bub_alu_ungated", a_alu, 32'h77);
        stall_m = 1'b1;
        tick();
        tick();
        stall_m = 1'b0;
        check("bub_stall_cnt", a_cnt, 4);
        flush_m = 1'b1;  // flush with invalid output still counts
        tick();
        flush_m = 1'b0;
        check("bub_flush_cnt", a_cnt, 5);

        // ---- Saturation, CNT_W = 4 ----
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        check("sat_cnt15", c_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt20", c_cnt, 15);
        check("nosat_cnt20", a_cnt, 20);
        #2;
        rst_n = 1'b0;  // between edges
        #1;
        check("async_rst_cnt", c_cnt, 0);
        check("async_rst_cnt16", a_cnt, 0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exmem_pipe_reg.md
# exmem_pipe_reg

Parametrised EX→MEM pipeline register for the pipelined RISC-V core, replacing the plain fixed-width latch between execute and memory. Carries ALU result, store data, destination register, PC+4 and MEM/WB control bits through `DEPTH` register stages. Adds a per-stage valid bit, stall (hold), flush (bubble insertion) and a saturating bubble counter, so the hazard unit can drive it directly.

## Interface
- `XLEN`, default 32: width of the data and PC fields.
- `RA_W`, default 5: register-address width.
- `DEPTH`, default 1: number of register stages, 1..4. Values above 1 serve multi-cycle memory paths.
- `CNT_W`, default 16: bubble-counter width.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_m`  in  1  hold all stages.
- `flush_m`  in  1  invalidate all stages.
- `valid_e`  in  1  EX-stage instruction valid.
- `alu_result_e`  in  XLEN  ALU result.
- `write_data_e`  in  XLEN  store data (RD2E).
- `rd_e`  in  RA_W  destination register.
- `pc_plus4_e`  in  XLEN  PC+4.
- `reg_write_e`  in  1  register write enable.
- `mem_write_e`  in  1  memory write enable.
- `result_src_e`  in  2  writeback source select.
- `valid_m`  out  1  output stage valid.
- `alu_result_m`, `write_data_m`, `pc_plus4_m`  out  XLEN  each, the registered data fields.
- `rd_m`  out  RA_W  registered destination register.
- `reg_write_m`, `mem_write_m`  out  1  each, registered enable ANDed with `valid_m`.
- `result_src_m`  out  2  registered writeback select.
- `bubble_cnt`  out  CNT_W  saturating count of bubbles presented at the output.

## Operation
- The register chain runs stage[0] → stage[DEPTH-1]. Each stage holds {valid, alu_result, write_data, rd, pc_plus4, reg_write, mem_write, result_src}.
- Outputs always come from stage[DEPTH-1].
- On `rst_n` = 0, asynchronously and immediately:
  - every stage field is cleared to 0, so every output reads 0;
  - `bubble_cnt` is cleared to 0.
- Priority per rising edge is flush > stall > advance.
- **Flush** (`flush_m` = 1): every stage is fully cleared to 0, valid and control included. Inputs are discarded. Flush wins over a simultaneous stall.
- **Stall** (`stall_m` = 1, `flush_m` = 0): all stages hold their values, and the inputs are ignored.
- **Advance**: stage[0] loads the inputs, with valid = `valid_e`, and stage[i] loads stage[i-1].
  - When `valid_e` = 0, stage[0] is still written with the inputs, but its valid = 0.
  - The gated enables then keep the bubble harmless.
- `reg_write_m` = stage valid & reg_write, and `mem_write_m` = stage valid & mem_write. This gating is combinational on registered bits.
- The data fields `alu_result_m`, `write_data_m`, `rd_m` and `pc_plus4_m` are passed ungated.
- **bubble_cnt** increments by 1 on each edge where all of these hold:
  - `rst_n` = 1;
  - `stall_m` = 0;
  - `valid_m` = 0 before the edge.
- `bubble_cnt` saturates at 2^CNT_W−1 and never wraps. Flush does not clear it.
- A flush edge whose pre-edge `valid_m` = 0 still counts as a bubble.
- `DEPTH` outside 1..4 is a parameter error; the implementation must add an elaboration-time check.

## Timing
- Latency: an input sampled at edge N appears at the outputs after edge N+DEPTH−1, provided no stall intervenes. For `DEPTH` = 1 it appears right after the sampling edge.
- Each cycle with `stall_m` = 1 adds exactly one cycle of latency to every in-flight entry.
- Throughput is one entry per cycle.
- No combinational path exists from any input to any output.
- Reset mid-operation loses all in-flight entries. The first edge after release behaves as a normal advance.

## Test plan
- Reset then stream, `DEPTH` = 1:
  - Stimulus: hold `rst_n` low, then drive `alu_result_e` = 0x0000_00A5, `rd_e` = 5, `reg_write_e` = 1, `valid_e` = 1.
  - Required: during reset all outputs read 0. After the first edge, `alu_result_m` = 0xA5, `rd_m` = 5 and `reg_write_m` = 1.
- Stall hold:
  - Stimulus: load value X = 0x1234, then assert `stall_m` for 3 cycles while the inputs change.
  - Required: the outputs stay at 0x1234 for those 3 cycles, and the new input appears on the edge after `stall_m` falls.
- Flush vs. stall:
  - Stimulus: with a valid entry at the output, assert `flush_m` and `stall_m` on the same edge.
  - Required: `valid_m` = 0, `reg_write_m` = 0, `mem_write_m` = 0, and all data outputs = 0.
- `DEPTH` = 3 latency:
  - Stimulus: send 3 consecutive valid entries A, B, C.
  - Required: A appears after the third edge, then B and C on the following edges.
  - Stimulus: then flush once.
  - Required: all 3 entries vanish and `valid_m` stays 0 until new entries propagate.
- Bubble gating and count:
  - Stimulus: drive `valid_e` = 0 with `reg_write_e` = 1 and `mem_write_e` = 1 for 4 cycles after reset.
  - Required: `reg_write_m` = 0, `mem_write_m` = 0, and `bubble_cnt` = 4.
  - Stimulus: then apply 2 stalled cycles.
  - Required: `bubble_cnt` stays at 4.
- Saturation, `CNT_W` = 4:
  - Stimulus: 20 bubble cycles.
  - Required: `bubble_cnt` stops at 15.
  - Stimulus: assert `rst_n` asynchronously between edges.
  - Required: `bubble_cnt` = 0 immediately.
